// File: rtl/mult_engine17.sv
// Sequential 16x16 signed Booth multiplier for the lab 17 DUT.
// Loads operands from data memory, multiplies, stores product big-endian.
module mult_engine17 #(
  parameter logic [7:0] OPA_ADDR = 8'd1,
  parameter logic [7:0] RES_ADDR = 8'd5
) (
  input  logic       CLK,
  input  logic       start,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic       halt
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  bcnt;
  logic [3:0]  step;
  logic [15:0] m;
  logic [16:0] a;
  logic [15:0] q;
  logic        q1;

  logic [16:0] msx;
  logic [16:0] sum;
  logic [16:0] a_nx;
  logic [15:0] q_nx;
  logic [23:0] p_lo;
  logic [7:0]  nxt_byte;

  // One Booth step: add/sub, then arithmetic shift of {A,Q,q_1}
  always_comb begin
    msx = {m[15], m};
    sum = a;
    unique case ({q[0], q1})
      2'b01:   sum = a + msx;
      2'b10:   sum = a - msx;
      default: sum = a;
    endcase
    a_nx = {sum[16], sum[16:1]};
    q_nx = {sum[0], q[15:1]};
  end

  always_comb begin
    p_lo = {a[7:0], q};
    nxt_byte = 8'h00;
    unique case (bcnt)
      2'd0:    nxt_byte = p_lo[23:16];
      2'd1:    nxt_byte = p_lo[15:8];
      2'd2:    nxt_byte = p_lo[7:0];
      default: nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      state     <= S_LOAD;
      bcnt      <= 2'd0;
      step      <= 4'd0;
      mem_addr  <= OPA_ADDR;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      halt      <= 1'b0;
      m         <= 16'h0000;
      a         <= 17'h00000;
      q         <= 16'h0000;
      q1        <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          mem_addr <= mem_addr + 8'd1;
          bcnt     <= bcnt + 2'd1;
          unique case (bcnt)
            2'd0: m[15:8] <= mem_rdata;
            2'd1: m[7:0]  <= mem_rdata;
            2'd2: q[15:8] <= mem_rdata;
            2'd3: begin
              q[7:0] <= mem_rdata;
              a      <= 17'h00000;
              q1     <= 1'b0;
              step   <= 4'd0;
              state  <= S_MUL;
            end
          endcase
        end
        S_MUL: begin
          a    <= a_nx;
          q    <= q_nx;
          q1   <= q[0];
          step <= step + 4'd1;
          if (step == 4'd15) begin
            mem_addr  <= RES_ADDR;
            mem_wdata <= a_nx[15:8];
            mem_we    <= 1'b1;
            bcnt      <= 2'd0;
            state     <= S_STORE;
          end
        end
        S_STORE: begin
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            mem_we <= 1'b0;
            halt   <= 1'b1;
            state  <= S_DONE;
          end else begin
            mem_addr  <= mem_addr + 8'd1;
            mem_wdata <= nxt_byte;
          end
        end
        S_DONE: begin
          mem_we <= 1'b0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_engine17.sv
// Scoreboard bench for mult_engine17 with a 256x8 memory model.
// Expected products come from plain signed integer multiplication.
module tb_mult_engine17;

  localparam logic [7:0] OPA = 8'd1;
  localparam logic [7:0] RES = 8'd5;

  logic       CLK = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       halt;

  logic       tb_wr = 1'b0;
  logic [7:0] tb_waddr = 8'h00;
  logic [7:0] tb_wdata = 8'h00;
  logic [7:0] mem [256];

  int cyc;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        ab;
    logic [31:0] exp;
  } item_t;

  item_t q_exp[$];

  mult_engine17 #(
    .OPA_ADDR(OPA),
    .RES_ADDR(RES)
  ) dut (
    .CLK(CLK),
    .start(start),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .halt(halt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (tb_wr) mem[tb_waddr] <= tb_wdata;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = mem[mem_addr];

  always @(posedge CLK or posedge start) begin
    if (start) cyc <= 0;
    else if (!halt) cyc <= cyc + 1;
  end

  function automatic logic [31:0] prod(input logic [15:0] x,
                                       input logic [15:0] y);
    int r;
    r = int'($signed(x)) * int'($signed(y));
    return r;
  endfunction

  function automatic logic [31:0] res_word();
    return {mem[RES], mem[RES + 8'd1],
            mem[RES + 8'd2], mem[RES + 8'd3]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: all checking happens here, on the falling edge
  initial begin : monitor
    logic  pstart;
    logic  phalt;
    item_t it;
    pstart = 1'b0;
    phalt  = 1'b0;
    forever begin
      @(negedge CLK);
      if (start === 1'b1 && pstart !== 1'b1) begin
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, {24'd0, OPA});
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        if (q_exp.size() > 0) begin
          it = q_exp.pop_front();
          chk("abort_kind", {31'd0, it.ab}, 32'd1);
          chk("abort_mem", res_word(), it.exp);
        end
      end
      if (mem_we === 1'b1) begin
        chk("we_addr", {24'd0, mem_addr},
            32'(RES) + 32'(cyc - 20));
        vectors++;
        if (!(cyc >= 20 && cyc <= 23)) begin
          miscompares++;
          $display("FAIL we_edge: write at edge %0d, required 21..24",
                   cyc + 1);
        end
      end
      if (halt === 1'b1 && phalt !== 1'b1) begin
        if (q_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_halt: halt=1, required 0");
        end else begin
          it = q_exp.pop_front();
          chk("halt_kind", {31'd0, it.ab}, 32'd0);
          chk("product", res_word(), it.exp);
          chk("cycles", 32'(cyc), 32'd24);
        end
      end
      if (start === 1'b0 && halt !== 1'b1 && cyc == 40) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout: halt=%b after %0d edges, required 24",
                 halt, cyc);
      end
      pstart = start;
      phalt  = halt;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic poke(input logic [7:0] ad, input logic [7:0] d);
    tb_wr    = 1'b1;
    tb_waddr = ad;
    tb_wdata = d;
    tick();
    tb_wr = 1'b0;
  endtask

  task automatic load(input logic [15:0] x, input logic [15:0] y);
    start = 1'b1;
    tick();
    poke(OPA, x[15:8]);
    poke(OPA + 8'd1, x[7:0]);
    poke(OPA + 8'd2, y[15:8]);
    poke(OPA + 8'd3, y[7:0]);
    for (int i = 0; i < 4; i++) poke(RES + 8'(i), 8'h00);
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] y,
                     input logic [31:0] e);
    load(x, y);
    q_exp.push_back('{1'b0, e});
    start = 1'b0;
    for (int i = 0; i < 60 && halt !== 1'b1; i++) tick();
    tick();
  endtask

  task automatic abort_at(input logic [15:0] x, input logic [15:0] y,
                          input int n, input logic [31:0] e);
    load(x, y);
    q_exp.push_back('{1'b1, e});
    start = 1'b0;
    for (int i = 0; i < 60 && cyc != n; i++) tick();
    start = 1'b1;
    tick();
    tick();
  endtask

  initial begin : stim
    logic [31:0] rv;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] pr;
    #1 start = 1'b1;
    repeat (10) tick();
    run(16'h0003, 16'h0005, 32'h0000000F);
    run(16'hFFFF, 16'hFFFF, 32'h00000001);
    run(16'h04D2, 16'hFFFE, 32'hFFFFF65C);
    run(16'h8000, 16'h8000, 32'h40000000);
    run(16'h8000, 16'h7FFF, 32'hC0008000);
    run(16'h0000, 16'h7FFF, 32'h00000000);
    abort_at(16'h1234, 16'h5678, 12, 32'h00000000);
    run(16'h0003, 16'h0005, 32'h0000000F);
    pr = prod(16'h04D2, 16'hFFFE);
    abort_at(16'h04D2, 16'hFFFE, 22, {pr[31:16], 16'h0000});
    run(16'h04D2, 16'hFFFE, pr);
    for (int k = 0; k < 1000; k++) begin
      rv = $urandom;
      ra = rv[15:0];
      rb = rv[31:16];
      run(ra, rb, prod(ra, rb));
    end
    start = 1'b1;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
